// File: rtl/vdma_pkg.sv
// vdma_pkg: shared AXI encodings, constants and helpers for the VDMA schedulers
// Contents: burst/resp encodings, 4 KB boundary, MODE selectors, state type, clog2
package vdma_pkg;
    localparam logic [1:0]  BURST_INCR  = 2'b01;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam int          BOUNDARY_4K = 4096;
    localparam logic [31:0] MODE_ONCE   = "ONCE";
    localparam logic [31:0] MODE_LINE   = "LINE";

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        ISSUE,
        DRAIN
    } rd_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/vdma_burst_len_calc.sv
// vdma_burst_len_calc: burst length = min(rem, MAX_BURST, beats left before the next 4 KB boundary)
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : capture the computed length into len_q
//   rem        : beats remaining in the current walk
//   addr_lo    : low 12 bits of the BYTES-aligned burst address
//   len        : combinational length (LSIZE+1 bits, range 1..2**LSIZE)
//   len_q      : registered length
module vdma_burst_len_calc
    import vdma_pkg::*;
#(
    parameter int LSIZE     = 8,
    parameter int MAX_BURST = 128,
    parameter int BYTES     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [31:0]      rem,
    input  logic [11:0]      addr_lo,
    output logic [LSIZE:0]   len,
    output logic [LSIZE:0]   len_q
);
    localparam int BSHIFT = clog2(BYTES);
    localparam int LW     = LSIZE + 1;

    logic [12:0] to_4k;
    logic [31:0] cap;
    logic [31:0] lim;

    always_comb begin
        to_4k = (13'(BOUNDARY_4K) - {1'b0, addr_lo}) >> BSHIFT;
        cap   = (rem < 32'(MAX_BURST)) ? rem : 32'(MAX_BURST);
        lim   = (cap < 32'(to_4k)) ? cap : 32'(to_4k);
        len   = LW'(lim);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) len_q <= '0;
        else if (en) len_q <= len;
    end
endmodule

// File: rtl/vdma_rd_burst_sched.sv
// vdma_rd_burst_sched: AXI4 read-address scheduler walking a frame in ONCE or LINE mode
// Ports:
//   axi_aclk, axi_resetn        : clock, asynchronous active-low reset
//   frame_start + config inputs : base_addr, line_beats, line_count, line_stride (latched on start)
//   fifo_free                   : downstream FIFO free entries, gates issue together with outstanding
//   axi_ar*                     : AR channel (arid/arsize/arburst constant)
//   axi_r*                      : R channel, observed only, for credit return and error tracking
//   busy, frame_done, frame_overrun, rd_err : status
module vdma_rd_burst_sched
    import vdma_pkg::*;
#(
    parameter int          ASIZE           = 32,
    parameter int          AXI_DSIZE       = 256,
    parameter int          LSIZE           = 8,
    parameter int          IDSIZE          = 4,
    parameter int          ID              = 0,
    parameter int          MAX_BURST       = 128,
    parameter int          MAX_OUTSTANDING = 4,
    parameter int          CSIZE           = 10,
    parameter logic [31:0] MODE            = "LINE"
) (
    input  logic              axi_aclk,
    input  logic              axi_resetn,
    input  logic              frame_start,
    input  logic [ASIZE-1:0]  base_addr,
    input  logic [15:0]       line_beats,
    input  logic [15:0]       line_count,
    input  logic [ASIZE-1:0]  line_stride,
    input  logic [CSIZE-1:0]  fifo_free,
    output logic [IDSIZE-1:0] axi_arid,
    output logic [ASIZE-1:0]  axi_araddr,
    output logic [LSIZE-1:0]  axi_arlen,
    output logic [2:0]        axi_arsize,
    output logic [1:0]        axi_arburst,
    output logic              axi_arvalid,
    input  logic              axi_arready,
    input  logic              axi_rvalid,
    input  logic              axi_rready,
    input  logic              axi_rlast,
    input  logic [1:0]        axi_rresp,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_overrun,
    output logic              rd_err
);
    localparam int BYTES  = AXI_DSIZE / 8;
    localparam int BSHIFT = clog2(BYTES);
    localparam int OW     = clog2(MAX_OUTSTANDING + 1);
    localparam bit ONCE   = (MODE == MODE_ONCE);

    rd_state_t        state;
    logic [ASIZE-1:0] addr;
    logic [ASIZE-1:0] line_addr;
    logic [ASIZE-1:0] stride_q;
    logic [15:0]      line_beats_q;
    logic [15:0]      lines_left;
    logic [31:0]      rem_line;
    logic [31:0]      reserved;
    logic [OW-1:0]    outstanding;
    logic [LSIZE:0]   len;
    logic [LSIZE:0]   len_q;
    logic [LSIZE:0]   chk_len;
    logic             ar_hs;
    logic             r_beat;
    logic             r_done;
    logic             credit;

    assign axi_arid    = IDSIZE'(ID);
    assign axi_arsize  = 3'(BSHIFT);
    assign axi_arburst = BURST_INCR;

    vdma_burst_len_calc #(
        .LSIZE     (LSIZE),
        .MAX_BURST (MAX_BURST),
        .BYTES     (BYTES)
    ) u_len (
        .clk     (axi_aclk),
        .rst_n   (axi_resetn),
        .en      (state == CALC),
        .rem     (rem_line),
        .addr_lo (addr[11:0]),
        .len     (len),
        .len_q   (len_q)
    );

    // In CALC the freshly computed length is checked so arvalid can rise on entry to ISSUE;
    // afterwards the registered length is rechecked every cycle while waiting for credit.
    always_comb begin
        ar_hs   = axi_arvalid & axi_arready;
        r_beat  = axi_rvalid & axi_rready;
        r_done  = r_beat & axi_rlast;
        chk_len = (state == CALC) ? len : len_q;
        credit  = (32'(fifo_free) >= reserved + 32'(chk_len)) &&
                  (32'(outstanding) < 32'(MAX_OUTSTANDING));
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state         <= IDLE;
            addr          <= '0;
            line_addr     <= '0;
            stride_q      <= '0;
            line_beats_q  <= '0;
            lines_left    <= '0;
            rem_line      <= '0;
            reserved      <= '0;
            outstanding   <= '0;
            axi_araddr    <= '0;
            axi_arlen     <= '0;
            axi_arvalid   <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            frame_overrun <= 1'b0;
            rd_err        <= 1'b0;
        end else begin
            frame_done    <= 1'b0;
            frame_overrun <= frame_start & busy;
            // Net update so a same-cycle AR handshake and R beat are both accounted for.
            reserved      <= reserved + (ar_hs ? 32'(len_q) : 32'd0) - (r_beat ? 32'd1 : 32'd0);
            outstanding   <= outstanding + OW'(ar_hs) - OW'(r_done);
            if (r_beat && axi_rresp != RESP_OKAY) rd_err <= 1'b1;
            case (state)
                IDLE: if (frame_start) begin
                    rd_err       <= 1'b0;
                    busy         <= 1'b1;
                    addr         <= base_addr;
                    line_addr    <= base_addr;
                    stride_q     <= line_stride;
                    line_beats_q <= line_beats;
                    // ONCE mode treats the whole frame as a single contiguous line.
                    rem_line     <= ONCE ? 32'(line_beats) * 32'(line_count) : 32'(line_beats);
                    lines_left   <= ONCE ? 16'd1 : line_count;
                    state        <= (line_beats == 16'd0 || line_count == 16'd0) ? DRAIN : CALC;
                end
                CALC: begin
                    axi_araddr  <= addr;
                    axi_arlen   <= LSIZE'(len - 1'b1);
                    axi_arvalid <= credit;
                    state       <= ISSUE;
                end
                ISSUE: if (ar_hs) begin
                    axi_arvalid <= 1'b0;
                    state       <= CALC;
                    if (rem_line == 32'(len_q)) begin
                        if (lines_left > 16'd1) begin
                            line_addr  <= line_addr + stride_q;
                            addr       <= line_addr + stride_q;
                            rem_line   <= 32'(line_beats_q);
                            lines_left <= lines_left - 16'd1;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        rem_line <= rem_line - 32'(len_q);
                        addr     <= addr + (ASIZE'(len_q) << BSHIFT);
                    end
                end else if (!axi_arvalid) begin
                    axi_arvalid <= credit;
                end
                DRAIN: if (outstanding == '0) begin
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
